rd_b_bias_stream: RTL
=====================

# rd_b_bias_stream

Parametrised successor bias reader for the LeNet-5 conv/FC blocks. On a start command it fetches a run-time-selectable burst of output-channel biases from a single-port bias BRAM, starting at any address with wrap-around. It streams them to the accumulator stage through a valid/ready interface with a small elastic buffer, so the consumer may stall without losing data. It supports 1- or 2-cycle BRAM read latency and gates BRAM enable to the actual read cycles.

## Interface
- OCH, 16, total bias words in BRAM (depth); AW = $clog2(OCH)
- OCH_B, 4, output-channel block factor; OCH_T = OCH/OCH_B = max burst length; IDX_BW = max(1,$clog2(OCH_T)); LEN_BW = $clog2(OCH_T+1)
- B_BW, 16, bias word width
- BRAM_LAT, 1, BRAM read latency in cycles (legal: 1 or 2)
- FIFO_D, 4, elastic buffer depth (must be >= BRAM_LAT+2, power of two)
- clk  in  1  clock, all logic on rising edge
- areset_n  in  1  asynchronous active-low reset
- i_run  in  1  start pulse, accepted only when o_idle=1
- i_rd_start_addr  in  AW  first BRAM address, sampled with accepted i_run
- i_rd_len  in  LEN_BW  burst length, sampled with accepted i_run; 0 means OCH_T
- o_idle  out  1  no burst in progress
- o_run  out  1  burst in progress (= !o_idle)
- o_n_ready  out  1  one-cycle pulse on the cycle the final BRAM read is issued
- o_en_err  out  1  sticky error flag, cleared only by reset
- o_ot_idx  out  IDX_BW  index of current output beat within burst (0..len-1)
- o_ot_bias  out  B_BW  bias data; forced to 0 when o_ot_valid=0
- o_ot_valid  out  1  output beat valid
- i_ot_ready  in  1  consumer accepts beat when valid&ready
- o_ot_done  out  1  asserted with the last beat of the burst (valid&last); held with it under stall
- b_o_bias_addr  out  AW  BRAM address
- b_o_bias_ce  out  1  BRAM enable, high only on read-issue cycles
- b_o_bias_we  out  1  tied 0 (read-only)
- b_i_bias_q  in  B_BW  BRAM read data, valid BRAM_LAT cycles after issue

## Operation
- FSM: IDLE -> ISSUE on accepted i_run; ISSUE -> DRAIN on the final read issue; DRAIN -> IDLE on the cycle after the last beat is accepted (valid&ready&last).
- Accepted start: latch start addr and len (0 -> OCH_T); clear issue counter, beat counter and outstanding count.
- Issue rule: in ISSUE, issue one read when (fifo occupancy + in-flight reads) < FIFO_D. Issue drives ce=1 and addr = current address. Address increments by 1 modulo OCH, so OCH-1 wraps to 0.
- In-flight tracking: a BRAM_LAT-deep shift register of issue flags. When the flag exits, write b_i_bias_q into the FIFO. Credit check guarantees no overflow.
- Output: o_ot_valid = FIFO non-empty. Pop on valid&ready. o_ot_idx = beat counter, which increments on each pop and resets at start.
- Errors (set o_en_err, no other effect): i_run while o_idle=0, including the DRAIN/done cycle; i_rd_len > OCH_T at i_run (request is also ignored and the FSM stays IDLE).
- Reset (async, any time, mid-burst included): FSM IDLE, FIFO and counters cleared, in-flight flags dropped. Outputs: o_idle=1; o_run, o_n_ready, o_en_err, o_ot_valid, o_ot_done, b_o_bias_ce, b_o_bias_we = 0; o_ot_idx, o_ot_bias, b_o_bias_addr = 0.

## Timing
- i_run sampled at edge 0. First read is issued in cycle 1. With i_ot_ready=1, o_ot_valid first rises in cycle 2+BRAM_LAT, i.e. the FIFO adds one register stage.
- No stall: len beats on consecutive cycles. o_ot_done coincides with beat len-1 in cycle 1+BRAM_LAT+len. o_idle=1 the following cycle.
- Defaults (BRAM_LAT=1, len=4): reads in cycles 1-4; o_n_ready in cycle 4; valid in cycles 3-6; done in cycle 6; idle in cycle 7. This is 6-cycle latency.
- Stall: while i_ot_ready=0, o_ot_bias, o_ot_idx, o_ot_valid and o_ot_done hold. Issue pauses once credits are exhausted and resumes the cycle after a pop frees a credit.
- The next i_run is accepted no earlier than the cycle o_idle=1.

## Test plan
- Defaults, BRAM[a]=0x100+a, start=0, len=0, ready=1 -> beats 0x100..0x103, idx 0..3, valid cycles 3-6, done at cycle 6 only, o_n_ready at cycle 4, ce high only in cycles 1-4.
- Wrap: start=14, len=4 -> addresses 14,15,0,1; data 0x10E,0x10F,0x100,0x101.
- Backpressure: ready toggled 1,0,0,1,0,1… with len=4 -> every beat delivered exactly once and in order; data held stable during stall; no more than FIFO_D reads outstanding; done on idx 3 only.
- BRAM_LAT=2, len=3, start=5 -> first valid at cycle 4; data 0x105..0x107; done at cycle 6.
- Errors: i_run during a burst -> o_en_err=1, burst completes unchanged. Separately, len=5 at OCH_T=4 -> o_en_err=1 and FSM stays IDLE.
- Reset: areset_n low during cycle 3 of a burst -> all outputs at reset values immediately; after release, a new burst with start=2, len=2 returns 0x102, 0x103 correctly.

Source files
------------

// File: rtl/rd_b_bias_stream.sv
// rd_b_bias_stream: burst bias reader from single-port BRAM with elastic valid/ready output
module rd_b_bias_stream #(
  parameter int OCH = 16,
  parameter int OCH_B = 4,
  parameter int B_BW = 16,
  parameter int BRAM_LAT = 1,
  parameter int FIFO_D = 4,
  localparam int AW = $clog2(OCH),
  localparam int OCH_T = OCH / OCH_B,
  localparam int IDX_BW = (OCH_T > 1) ? $clog2(OCH_T) : 1,
  localparam int LEN_BW = $clog2(OCH_T + 1)
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              i_run,
  input  logic [AW-1:0]     i_rd_start_addr,
  input  logic [LEN_BW-1:0] i_rd_len,
  output logic              o_idle,
  output logic              o_run,
  output logic              o_n_ready,
  output logic              o_en_err,
  output logic [IDX_BW-1:0] o_ot_idx,
  output logic [B_BW-1:0]   o_ot_bias,
  output logic              o_ot_valid,
  input  logic              i_ot_ready,
  output logic              o_ot_done,
  output logic [AW-1:0]     b_o_bias_addr,
  output logic              b_o_bias_ce,
  output logic              b_o_bias_we,
  input  logic [B_BW-1:0]   b_i_bias_q
);
  localparam int FW = $clog2(FIFO_D);
  localparam int CW = FW + 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr;
  logic [LEN_BW-1:0] len, issue_cnt;
  logic [IDX_BW-1:0] beat;
  logic [BRAM_LAT-1:0] fl;
  logic [CW-1:0] infl, wp, rp, occ;
  logic [B_BW-1:0] mem [FIFO_D];
  logic accept, issue, last_issue, valid, pop, last_beat, land;
  assign occ        = wp - rp;
  assign land       = fl[BRAM_LAT-1];
  assign accept     = i_run && state == S_IDLE && i_rd_len <= LEN_BW'(OCH_T);
  assign issue      = state == S_ISSUE && (int'(occ) + int'(infl) < FIFO_D);
  assign last_issue = issue && issue_cnt == len - LEN_BW'(1);
  assign valid      = occ != '0;
  assign pop        = valid && i_ot_ready;
  assign last_beat  = valid && LEN_BW'(beat) == len - LEN_BW'(1);
  // next-state: a burst runs issue then drain, ending once its last beat is taken
  always_comb begin
    state_nx = state;
    state_nx = accept ? S_ISSUE : last_issue ? S_DRAIN : (state == S_DRAIN && pop && last_beat) ? S_IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) state <= S_IDLE;
    else state <= state_nx;
  // burst bookkeeping: address walk, counters, in-flight reads, FIFO pointers, sticky error
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      addr      <= '0;
      len       <= '0;
      issue_cnt <= '0;
      beat      <= '0;
      fl        <= '0;
      infl      <= '0;
      wp        <= '0;
      rp        <= '0;
      o_en_err  <= 1'b0;
    end else begin
      if (i_run && (state != S_IDLE || i_rd_len > LEN_BW'(OCH_T))) o_en_err <= 1'b1;
      fl   <= BRAM_LAT'({fl, issue});
      infl <= infl + CW'(issue) - CW'(land);
      if (land) wp <= wp + CW'(1);
      if (pop) begin
        rp   <= rp + CW'(1);
        beat <= beat + IDX_BW'(1);
      end
      if (accept) begin
        addr      <= i_rd_start_addr;
        len       <= i_rd_len == '0 ? LEN_BW'(OCH_T) : i_rd_len;
        issue_cnt <= '0;
        beat      <= '0;
      end else if (issue) begin
        addr      <= addr == AW'(OCH - 1) ? '0 : addr + AW'(1);
        issue_cnt <= issue_cnt + LEN_BW'(1);
      end
    end
  // elastic buffer storage, written as each read's data returns
  always_ff @(posedge clk)
    if (land) mem[wp[FW-1:0]] <= b_i_bias_q;
  assign o_idle        = state == S_IDLE;
  assign o_run         = !o_idle;
  assign o_n_ready     = last_issue;
  assign o_ot_idx      = beat;
  assign o_ot_valid    = valid;
  assign o_ot_bias     = valid ? mem[rp[FW-1:0]] : '0;
  assign o_ot_done     = last_beat;
  assign b_o_bias_addr = addr;
  assign b_o_bias_ce   = issue;
  assign b_o_bias_we   = 1'b0;
endmodule
